// File: rtl/dual_slope_sequencer.sv
// Dual-slope ADC phase sequencer: auto-zero, integrate, de-integrate.
// Drives the shared phase counter and analog switches; captures the result.
module dual_slope_sequencer #(
    parameter int unsigned AZ_CYCLES  = 1000,
    parameter int unsigned INT_CYCLES = 10000,
    parameter int unsigned DEINT_MAX  = 20000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cont_i,
    input  logic        abort_i,
    input  logic        comp_i,
    input  logic        cnt_done_i,
    input  logic [15:0] cnt_count_i,
    output logic        cnt_en_o,
    output logic        cnt_clear_o,
    output logic [15:0] cnt_limit_o,
    output logic        sw_az_o,
    output logic        sw_in_o,
    output logic        sw_refp_o,
    output logic        sw_refn_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [15:0] result_o,
    output logic        sign_o,
    output logic        overrange_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARM_AZ  = 3'd1;
    localparam logic [2:0] S_AZ      = 3'd2;
    localparam logic [2:0] S_ARM_INT = 3'd3;
    localparam logic [2:0] S_INT     = 3'd4;
    localparam logic [2:0] S_ARM_DE  = 3'd5;
    localparam logic [2:0] S_DE      = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [15:0] LIM_AZ  = 16'(AZ_CYCLES);
    localparam logic [15:0] LIM_INT = 16'(INT_CYCLES);
    localparam logic [15:0] LIM_DE  = 16'(DEINT_MAX);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       latch_sign;
    logic       de_cross;
    logic       de_over;

    always_comb begin
        state_d    = state_q;
        latch_sign = 1'b0;
        de_cross   = 1'b0;
        de_over    = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) state_d = S_ARM_AZ;
                end
                S_ARM_AZ:  state_d = S_AZ;
                S_AZ: begin
                    if (cnt_done_i) state_d = S_ARM_INT;
                end
                S_ARM_INT: state_d = S_INT;
                S_INT: begin
                    if (cnt_done_i) begin
                        latch_sign = 1'b1;
                        state_d    = S_ARM_DE;
                    end
                end
                S_ARM_DE:  state_d = S_DE;
                S_DE: begin
                    // a comparator crossing beats a simultaneous timeout
                    if (comp_i != sign_o) begin
                        de_cross = 1'b1;
                        state_d  = S_DONE;
                    end else if (cnt_done_i) begin
                        de_over = 1'b1;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = cont_i ? S_ARM_AZ : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_en_o    <= 1'b0;
            cnt_clear_o <= 1'b1;
            cnt_limit_o <= 16'd0;
            sw_az_o     <= 1'b0;
            sw_in_o     <= 1'b0;
            sw_refp_o   <= 1'b0;
            sw_refn_o   <= 1'b0;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            result_o    <= 16'd0;
            sign_o      <= 1'b0;
            overrange_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_clear_o <= abort_i;
            cnt_en_o    <= (state_d == S_AZ) ||
                           (state_d == S_INT) ||
                           (state_d == S_DE);
            busy_o      <= (state_d != S_IDLE);
            valid_o     <= (state_d == S_DONE);
            // switches are decoded from the next state so they stay registered
            sw_az_o     <= (state_d == S_AZ);
            sw_in_o     <= (state_d == S_INT);
            sw_refp_o   <= (state_d == S_DE) && !sign_o;
            sw_refn_o   <= (state_d == S_DE) && sign_o;
            case (state_d)
                S_ARM_AZ:  cnt_limit_o <= LIM_AZ;
                S_ARM_INT: cnt_limit_o <= LIM_INT;
                S_ARM_DE:  cnt_limit_o <= LIM_DE;
                default:   cnt_limit_o <= cnt_limit_o;
            endcase
            if (latch_sign) sign_o <= comp_i;
            if (de_cross) begin
                result_o    <= cnt_count_i;
                overrange_o <= 1'b0;
            end else if (de_over) begin
                result_o    <= LIM_DE;
                overrange_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_slope_sequencer.sv
// Directed bench for dual_slope_sequencer with a behavioural phase counter.
// Checks reset, nominal, overrange, abort, continuous and switch invariants.
module tb_dual_slope_sequencer;

    localparam int unsigned AZ  = 10;
    localparam int unsigned INT = 20;
    localparam int unsigned MAX = 50;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        cont_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        comp_i;
    logic        cnt_done = 1'b0;
    logic [15:0] cnt_count = 16'd0;
    logic        cnt_en_o;
    logic        cnt_clear_o;
    logic [15:0] cnt_limit_o;
    logic        sw_az_o;
    logic        sw_in_o;
    logic        sw_refp_o;
    logic        sw_refn_o;
    logic        busy_o;
    logic        valid_o;
    logic [15:0] result_o;
    logic        sign_o;
    logic        overrange_o;

    logic        stuck0 = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          viol = 0;
    int          vcount = 0;
    int          busy_drop = 0;
    logic        watch_busy = 1'b0;
    logic        refn_seen = 1'b0;
    logic        refp_seen = 1'b0;
    logic [3:0]  prev_sw = 4'd0;

    always #5 clk = ~clk;

    dual_slope_sequencer #(
        .AZ_CYCLES (AZ),
        .INT_CYCLES(INT),
        .DEINT_MAX (MAX)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .cont_i     (cont_i),
        .abort_i    (abort_i),
        .comp_i     (comp_i),
        .cnt_done_i (cnt_done),
        .cnt_count_i(cnt_count),
        .cnt_en_o   (cnt_en_o),
        .cnt_clear_o(cnt_clear_o),
        .cnt_limit_o(cnt_limit_o),
        .sw_az_o    (sw_az_o),
        .sw_in_o    (sw_in_o),
        .sw_refp_o  (sw_refp_o),
        .sw_refn_o  (sw_refn_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .result_o   (result_o),
        .sign_o     (sign_o),
        .overrange_o(overrange_o)
    );

    // phase counter: disable arms it, done after `limit` enabled cycles
    always_ff @(posedge clk) begin
        if (cnt_clear_o || !cnt_en_o) begin
            cnt_count <= 16'd0;
            cnt_done  <= 1'b0;
        end else if (!cnt_done) begin
            cnt_count <= cnt_count + 16'd1;
            if (cnt_count + 16'd1 == cnt_limit_o) cnt_done <= 1'b1;
        end
    end

    // integrator: positive until 12 counts into a negative-ref de-integrate
    assign comp_i = stuck0 ? 1'b0 : !(sw_refn_o && cnt_count >= 16'd12);

    always @(posedge clk) begin
        logic [3:0] sw;
        #1;
        sw = {sw_az_o, sw_in_o, sw_refp_o, sw_refn_o};
        if ($countones(sw) > 1) viol++;
        if (prev_sw != 4'd0 && sw != 4'd0 && sw != prev_sw) viol++;
        prev_sw = sw;
        if (valid_o) vcount++;
        if (sw_refn_o) refn_seen = 1'b1;
        if (sw_refp_o) refp_seen = 1'b1;
        if (watch_busy && !busy_o) busy_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            if (valid_o) break;
            tick();
        end
        if (i == lim) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic start_conv();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int vb;
        int i;
        tick();
        tick();
        chk("rst_sw", 32'({sw_az_o, sw_in_o, sw_refp_o, sw_refn_o}), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_clear", 32'(cnt_clear_o), 32'd1);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_en", 32'(cnt_en_o), 32'd0);
        chk("rst_flags", 32'({sign_o, overrange_o}), 32'd0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_clear", 32'(cnt_clear_o), 32'd0);

        // nominal conversion, positive input
        refn_seen = 1'b0;
        refp_seen = 1'b0;
        vb = vcount;
        start_conv();
        chk("nom_busy", 32'(busy_o), 32'd1);
        chk("nom_arm_limit", 32'(cnt_limit_o), 32'(AZ));
        wait_valid("nom", 500);
        chk("nom_result", 32'(result_o), 32'd12);
        chk("nom_sign", 32'(sign_o), 32'd1);
        chk("nom_ovr", 32'(overrange_o), 32'd0);
        chk("nom_refn", 32'({refn_seen, refp_seen}), 32'd2);
        tick();
        chk("nom_valid_pulse", 32'(valid_o), 32'd0);
        chk("nom_idle", 32'(busy_o), 32'd0);
        chk("nom_vcount", 32'(vcount - vb), 32'd1);

        // overrange, also a start during the run must be ignored
        stuck0 = 1'b1;
        refn_seen = 1'b0;
        refp_seen = 1'b0;
        vb = vcount;
        start_conv();
        for (i = 0; i < 5; i++) tick();
        start_conv();
        wait_valid("ovr", 500);
        chk("ovr_result", 32'(result_o), 32'(MAX));
        chk("ovr_flag", 32'(overrange_o), 32'd1);
        chk("ovr_sign", 32'(sign_o), 32'd0);
        chk("ovr_refp", 32'({refn_seen, refp_seen}), 32'd1);
        for (i = 0; i < 4; i++) tick();
        chk("ovr_no_queue", 32'(busy_o), 32'd0);
        chk("ovr_vcount", 32'(vcount - vb), 32'd1);
        stuck0 = 1'b0;

        // abort during integrate
        start_conv();
        for (i = 0; i < 100 && !sw_in_o; i++) tick();
        chk("abt_in_int", 32'(sw_in_o), 32'd1);
        tick();
        tick();
        vb = vcount;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abt_busy", 32'(busy_o), 32'd0);
        chk("abt_clear", 32'(cnt_clear_o), 32'd1);
        chk("abt_sw", 32'(sw_in_o), 32'd0);
        chk("abt_result", 32'(result_o), 32'(MAX));
        tick();
        chk("abt_clear_1cyc", 32'(cnt_clear_o), 32'd0);
        for (i = 0; i < 100; i++) tick();
        chk("abt_no_valid", 32'(vcount - vb), 32'd0);

        // abort and start together: abort wins
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abt_start_idle", 32'(busy_o), 32'd0);

        // continuous mode, three conversions
        cont_i = 1'b1;
        vb = vcount;
        start_conv();
        watch_busy = 1'b1;
        for (i = 0; i < 2000 && (vcount - vb) < 3; i++) tick();
        cont_i = 1'b0;
        watch_busy = 1'b0;
        chk("cont_vcount", 32'(vcount - vb), 32'd3);
        chk("cont_busy_held", 32'(busy_drop), 32'd0);
        chk("cont_result", 32'(result_o), 32'd12);
        tick();
        chk("cont_stop", 32'(busy_o), 32'd0);

        // reset mid-conversion
        start_conv();
        for (i = 0; i < 30; i++) tick();
        chk("mid_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_result", 32'(result_o), 32'd0);
        chk("mid_rst_clear", 32'(cnt_clear_o), 32'd1);
        chk("mid_rst_sw", 32'({sw_az_o, sw_in_o, sw_refp_o, sw_refn_o}), 32'd0);
        tick();

        chk("sw_invariant", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
